// File: rtl/shift_reg_sipo.sv
// shift_reg_sipo: serial-in/parallel-out deserializer.
// Gathers WIDTH strobed bits into a word and presents each completed word on
// a registered output with a VALID/READY handshake. A word that completes
// while the previous word is still unconsumed is dropped, and OVF latches.
module shift_reg_sipo #(
  parameter int               WIDTH      = 8,
  parameter int               CNT_W      = 3,
  parameter logic [WIDTH-1:0] CLEAR_WORD = '0,
  parameter bit               MSB_FIRST  = 1'b1
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             D,
  input  logic             EN,
  input  logic             SYNC,
  input  logic             RDY,
  input  logic             OCLR,
  output logic [WIDTH-1:0] Q,
  output logic             VLD,
  output logic             OVF,
  output logic [CNT_W-1:0] CNT
);

  logic [WIDTH-1:0] r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic             r_vld;
  logic             r_ovf;

  logic [WIDTH-1:0] w_shift;
  logic             w_last;
  logic             w_done;
  logic             w_load;
  logic             w_drop;
  logic             w_consume;

  // Next shift-register value and word-completion / handshake decode.
  always_comb begin
    w_shift   = '0;
    if (MSB_FIRST) begin
      w_shift = {r_sr[WIDTH-2:0], D};
    end else begin
      w_shift = {D, r_sr[WIDTH-1:1]};
    end
    w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    w_done    = EN && !SYNC && w_last;
    w_consume = r_vld && RDY;
    w_load    = w_done && (!r_vld || RDY);
    w_drop    = w_done && r_vld && !RDY;
  end

  // Shift register: resync loads the clear word, otherwise shift on strobe.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_sr <= CLEAR_WORD;
    end else if (SYNC) begin
      r_sr <= CLEAR_WORD;
    end else if (EN) begin
      r_sr <= w_shift;
    end
  end

  // Bit counter: counts strobes within a word, wraps on the last bit.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_cnt <= '0;
    end else if (SYNC) begin
      r_cnt <= '0;
    end else if (EN) begin
      if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Output word and valid flag: load on completion when the slot is free or
  // being consumed in the same cycle; otherwise drop valid on consume.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_q   <= CLEAR_WORD;
      r_vld <= 1'b0;
    end else if (w_load) begin
      r_q   <= w_shift;
      r_vld <= 1'b1;
    end else if (w_consume) begin
      r_vld <= 1'b0;
    end
  end

  // Sticky overflow: a dropped word sets it and takes priority over clear.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (OCLR) begin
      r_ovf <= 1'b0;
    end
  end

  assign Q   = r_q;
  assign VLD = r_vld;
  assign OVF = r_ovf;
  assign CNT = r_cnt;

endmodule
